// File: rtl/wb_unit.sv
// Write-back stage: retires ALU results directly and waits for data-memory read data on loads,
// extracting/extending the addressed byte or halfword. Aborts a load after TIMEOUT cycles in WAIT_MEM.
module wb_unit #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_reg_wrt,
  input  logic                 in_mem_to_reg,
  input  logic [4:0]           in_wrt_reg,
  input  logic [31:0]          in_alu_result,
  input  logic [1:0]           in_ld_size,
  input  logic                 in_ld_unsigned,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_rvalid,
  output logic [31:0]          wrt_dt,
  output logic [4:0]           wrt_reg,
  output logic                 reg_wrt,
  output logic                 pend_valid,
  output logic [4:0]           pend_reg,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] wb_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          tmo_reg, tmo_next;
  logic [4:0]             ld_dest_reg, ld_dest_next;
  logic                   ld_we_reg, ld_we_next;
  logic [1:0]             ld_off_reg, ld_off_next;
  logic [1:0]             ld_size_reg, ld_size_next;
  logic                   ld_uns_reg, ld_uns_next;
  logic [31:0]            dt_reg, dt_next;
  logic [4:0]             addr_reg, addr_next;
  logic                   strobe_reg, strobe_next;
  logic                   err_reg, err_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic                   accept;
  logic [7:0]             lane [4];
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [31:0]            load_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = mem_rdata[8*gi +: 8];
  end

  always_comb begin
    byte_sel  = lane[ld_off_reg];
    half_sel  = ld_off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (ld_size_reg)
      2'b00:   load_data = {{24{byte_sel[7] & ~ld_uns_reg}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~ld_uns_reg}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // in_ready is held low while reset is asserted, not just after the reset edge
  assign in_ready = rst_n & (state_reg == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next   = state_reg;
    tmo_next     = tmo_reg;
    ld_dest_next = ld_dest_reg;
    ld_we_next   = ld_we_reg;
    ld_off_next  = ld_off_reg;
    ld_size_next = ld_size_reg;
    ld_uns_next  = ld_uns_reg;
    dt_next      = dt_reg;
    addr_next    = addr_reg;
    strobe_next  = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_mem_to_reg) begin
            ld_dest_next = in_wrt_reg;
            ld_we_next   = in_reg_wrt;
            ld_off_next  = in_alu_result[1:0];
            ld_size_next = in_ld_size;
            ld_uns_next  = in_ld_unsigned;
            tmo_next     = '0;
            state_next   = WAIT_MEM;
          end else begin
            dt_next     = in_alu_result;
            addr_next   = in_wrt_reg;
            strobe_next = in_reg_wrt & (in_wrt_reg != 5'd0);
          end
        end
      end
      WAIT_MEM: begin
        // read data on the final timeout cycle still completes the load
        if (mem_rvalid) begin
          dt_next     = load_data;
          addr_next   = ld_dest_reg;
          strobe_next = ld_we_reg & (ld_dest_reg != 5'd0);
          state_next  = IDLE;
        end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    count_next = count_reg + CNT_WIDTH'(strobe_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tmo_reg     <= '0;
      ld_dest_reg <= '0;
      ld_we_reg   <= 1'b0;
      ld_off_reg  <= '0;
      ld_size_reg <= '0;
      ld_uns_reg  <= 1'b0;
      dt_reg      <= '0;
      addr_reg    <= '0;
      strobe_reg  <= 1'b0;
      err_reg     <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      tmo_reg     <= tmo_next;
      ld_dest_reg <= ld_dest_next;
      ld_we_reg   <= ld_we_next;
      ld_off_reg  <= ld_off_next;
      ld_size_reg <= ld_size_next;
      ld_uns_reg  <= ld_uns_next;
      dt_reg      <= dt_next;
      addr_reg    <= addr_next;
      strobe_reg  <= strobe_next;
      err_reg     <= err_next;
      count_reg   <= count_next;
    end
  end

  assign wrt_dt     = dt_reg;
  assign wrt_reg    = addr_reg;
  assign reg_wrt    = strobe_reg;
  assign err        = err_reg;
  assign wb_count   = count_reg;
  assign pend_valid = (state_reg == WAIT_MEM);
  assign pend_reg   = (state_reg == WAIT_MEM) ? ld_dest_reg : 5'd0;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: table of single retirements plus hand sequences for
// back-to-back ALU ops, load timeout and reset during an outstanding load.
module tb_wb_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_reg_wrt, in_mem_to_reg, in_ld_unsigned;
  logic [4:0]  in_wrt_reg;
  logic [31:0] in_alu_result, mem_rdata, wrt_dt;
  logic [1:0]  in_ld_size;
  logic        mem_rvalid, reg_wrt, pend_valid, err;
  logic [4:0]  wrt_reg, pend_reg;
  logic [15:0] wb_count;

  always #5 clk = ~clk;

  wb_unit #(.TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_wrt(in_reg_wrt), .in_mem_to_reg(in_mem_to_reg), .in_wrt_reg(in_wrt_reg),
    .in_alu_result(in_alu_result), .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .wrt_dt(wrt_dt), .wrt_reg(wrt_reg),
    .reg_wrt(reg_wrt), .pend_valid(pend_valid), .pend_reg(pend_reg), .err(err),
    .wb_count(wb_count)
  );

  typedef struct {
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] rdata;
    int          dly;   // edges after accept at which mem_rvalid is sampled
    logic        ewr;
    logic [31:0] edt;
  } vec_t;

  localparam int NV = 11;
  vec_t        vecs [NV];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m2r, input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [1:0] sz, input logic uns);
    in_valid = 1'b1; in_mem_to_reg = m2r; in_reg_wrt = rw; in_wrt_reg = rd;
    in_alu_result = alu; in_ld_size = sz; in_ld_unsigned = uns;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'h1234_5678, 2'b00, 1'b0, 32'h0,          0, 1'b1, 32'h1234_5678};
    vecs[1]  = '{1'b0, 1'b1, 5'd0,  32'h0000_DEAD, 2'b00, 1'b0, 32'h0,          0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 5'd7,  32'h0000_1002, 2'b00, 1'b0, 32'h0080_0000,  3, 1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{1'b1, 1'b1, 5'd9,  32'h0000_2006, 2'b01, 1'b1, 32'hBEEF_1234,  1, 1'b1, 32'h0000_BEEF};
    vecs[4]  = '{1'b1, 1'b1, 5'd31, 32'h0000_3000, 2'b10, 1'b0, 32'hCAFE_F00D,  4, 1'b1, 32'hCAFE_F00D};
    vecs[5]  = '{1'b1, 1'b1, 5'd2,  32'h0000_0001, 2'b01, 1'b0, 32'h1234_8001,  2, 1'b1, 32'hFFFF_8001};
    vecs[6]  = '{1'b1, 1'b1, 5'd4,  32'h0000_0003, 2'b00, 1'b1, 32'hAB00_0000,  1, 1'b1, 32'h0000_00AB};
    vecs[7]  = '{1'b1, 1'b1, 5'd6,  32'h0000_0003, 2'b11, 1'b0, 32'h8000_0001,  2, 1'b1, 32'h8000_0001};
    vecs[8]  = '{1'b1, 1'b0, 5'd8,  32'h0000_0000, 2'b10, 1'b0, 32'h1111_1111,  1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 5'd10, 32'h5555_AAAA, 2'b00, 1'b0, 32'h0,          0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 5'd11, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_7F00,  2, 1'b1, 32'h0000_007F};

    rst_n = 1'b0; in_valid = 1'b0; in_reg_wrt = 1'b0; in_mem_to_reg = 1'b0; in_wrt_reg = '0;
    in_alu_result = '0; in_ld_size = '0; in_ld_unsigned = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_reg_wrt", reg_wrt, 0);
    chk("rst_wrt_dt", wrt_dt, 0);
    chk("rst_wrt_reg", wrt_reg, 0);
    chk("rst_pend", pend_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_count", wb_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].m2r, vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].sz, vecs[i].uns);
      @(posedge clk); #1 in_valid = 1'b0;
      if (vecs[i].m2r) begin
        @(negedge clk);
        chk("wait_pend_valid", pend_valid, 1);
        chk("wait_pend_reg", pend_reg, vecs[i].rd);
        chk("wait_ready", in_ready, 0);
        repeat (vecs[i].dly - 1) @(posedge clk);
        #1 mem_rvalid = 1'b1; mem_rdata = vecs[i].rdata;
        @(posedge clk); #1 mem_rvalid = 1'b0;
      end
      @(negedge clk);
      exp_cnt += 16'(vecs[i].ewr);
      chk("vec_reg_wrt", reg_wrt, vecs[i].ewr);
      if (vecs[i].ewr) begin
        chk("vec_wrt_reg", wrt_reg, vecs[i].rd);
        chk("vec_wrt_dt", wrt_dt, vecs[i].edt);
      end
      chk("vec_err", err, 0);
      chk("vec_count", wb_count, exp_cnt);
      chk("vec_pend_clear", pend_valid, 0);
      $display("vec %0d: m2r=%0d rd=%0d reg_wrt=%0d wrt_dt=%h count=%0d",
               i, vecs[i].m2r, vecs[i].rd, reg_wrt, wrt_dt, wb_count);
      @(negedge clk);
      chk("vec_one_pulse", reg_wrt, 0);
      chk("vec_ready", in_ready, 1);
      @(posedge clk); #1;
    end

    // back-to-back: reg 0 then reg 3
    drive(1'b0, 1'b1, 5'd0, 32'h0000_0AAA, 2'b00, 1'b0);
    @(posedge clk); #1 drive(1'b0, 1'b1, 5'd3, 32'h0000_0333, 2'b00, 1'b0);
    @(negedge clk);
    chk("b2b_r0_wrt", reg_wrt, 0);
    chk("b2b_r0_count", wb_count, exp_cnt);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp_cnt += 16'd1;
    chk("b2b_r3_wrt", reg_wrt, 1);
    chk("b2b_r3_reg", wrt_reg, 3);
    chk("b2b_r3_dt", wrt_dt, 32'h0000_0333);
    chk("b2b_count", wb_count, exp_cnt);
    $display("b2b: reg_wrt=%0d wrt_reg=%0d count=%0d", reg_wrt, wrt_reg, wb_count);
    @(posedge clk); #1;

    // timeout: no read data, err after TIMEOUT cycles in WAIT_MEM
    begin
      int cyc;
      cyc = -1;
      drive(1'b1, 1'b1, 5'd12, 32'h0000_0000, 2'b10, 1'b0);
      @(posedge clk); #1 in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (err) begin
          cyc = c;
          break;
        end
        chk("tmo_no_wrt", reg_wrt, 0);
      end
      chk("tmo_cycles", cyc, 4);
      chk("tmo_reg_wrt", reg_wrt, 0);
      chk("tmo_ready", in_ready, 1);
      chk("tmo_pend", pend_valid, 0);
      chk("tmo_count", wb_count, exp_cnt);
      $display("timeout: err after %0d edges, ready=%0d", cyc, in_ready);
      @(negedge clk);
      chk("tmo_err_pulse", err, 0);
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      @(posedge clk); #1 mem_rvalid = 1'b0;
      @(negedge clk);
      chk("idle_rvalid_wrt", reg_wrt, 0);
      chk("idle_rvalid_count", wb_count, exp_cnt);
      chk("idle_rvalid_ready", in_ready, 1);
      @(posedge clk); #1;
    end

    // reset while a load is outstanding
    drive(1'b1, 1'b1, 5'd13, 32'h0000_0000, 2'b10, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mrst_ready", in_ready, 0);
    chk("mrst_reg_wrt", reg_wrt, 0);
    chk("mrst_wrt_dt", wrt_dt, 0);
    chk("mrst_wrt_reg", wrt_reg, 0);
    chk("mrst_pend", pend_valid, 0);
    chk("mrst_pend_reg", pend_reg, 0);
    chk("mrst_err", err, 0);
    chk("mrst_count", wb_count, 0);
    @(posedge clk); #1 mem_rvalid = 1'b0; rst_n = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("mrst_rel_ready", in_ready, 1);
    chk("mrst_rel_wrt", reg_wrt, 0);
    chk("mrst_rel_pend", pend_valid, 0);
    $display("reset mid-load: ready=%0d pend=%0d count=%0d", in_ready, pend_valid, wb_count);
    @(posedge clk); #1 drive(1'b0, 1'b1, 5'd1, 32'h0000_0005, 2'b00, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp_cnt += 16'd1;
    chk("post_rst_wrt", reg_wrt, 1);
    chk("post_rst_dt", wrt_dt, 32'h0000_0005);
    chk("post_rst_count", wb_count, exp_cnt);
    $display("post reset ALU: reg_wrt=%0d count=%0d", reg_wrt, wb_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
Write-back stage that produces the register-file write port (wrt_dt, wrt_reg, reg_wrt) consumed by the decode/register-file stage. It accepts retiring instructions from the MEM stage over a valid/ready handshake. ALU results are written back directly. For loads it waits for data-memory read data, then byte/halfword-extracts and extends it. It also exposes the pending load destination for hazard detection, and handles memory timeouts.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT_MEM before the load is aborted (must be >= 1)
CNT_WIDTH, 16, width of the retired-write counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  unit can accept an instruction this cycle
in_reg_wrt  input  1  instruction writes a register
in_mem_to_reg  input  1  1 = load (data from memory), 0 = ALU result
in_wrt_reg  input  5  destination register number
in_alu_result  input  32  ALU result / load effective address
in_ld_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
in_ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend
mem_rdata  input  32  data-memory read data, little-endian
mem_rvalid  input  1  mem_rdata valid this cycle
wrt_dt  output  32  register write data
wrt_reg  output  5  register write address
reg_wrt  output  1  register write strobe, one cycle per write
pend_valid  output  1  load outstanding (state WAIT_MEM)
pend_reg  output  5  destination of outstanding load
err  output  1  one-cycle pulse on load timeout
wb_count  output  CNT_WIDTH  number of register writes issued

Behaviour:
- Reset (rst_n=0 at clk edge) sets every output to 0 (in_ready=0 during reset) and the state to IDLE, regardless of the current state. This includes reset during WAIT_MEM, where the pending load is discarded and no write is issued.
- States: IDLE, WAIT_MEM.
- in_ready = 1 in IDLE, 0 in WAIT_MEM. Accept = in_valid & in_ready.
- All write-port outputs are registered. reg_wrt defaults to 0 every cycle unless a write is issued.
- Accept with in_mem_to_reg=0:
  - Next cycle: reg_wrt = in_reg_wrt & (in_wrt_reg != 0), wrt_reg = in_wrt_reg, wrt_dt = in_alu_result. Latency 1.
  - Stay in IDLE; back-to-back accepts give consecutive reg_wrt pulses.
- Accept with in_mem_to_reg=1:
  - Latch in_wrt_reg, in_reg_wrt, in_alu_result[1:0], in_ld_size and in_ld_unsigned; go to WAIT_MEM.
  - Clear the timeout counter.
  - pend_valid=1 and pend_reg=latched destination from the next cycle on.
- WAIT_MEM:
  - mem_rvalid is sampled only in this state and ignored elsewhere.
  - On mem_rvalid: the next cycle drives the extracted data with reg_wrt = latched reg_wrt & (reg != 0). In that same edge, return to IDLE and drop pend_valid.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without mem_rvalid, pulse err=1 the next cycle, issue no write and return to IDLE.
  - mem_rvalid in the same cycle as the last timeout count wins: the write happens and err is not raised.
- Load extraction (off = latched addr[1:0]):
  - Byte: mem_rdata[8*off+7 : 8*off].
  - Half: off[1]=0 gives bits 15:0, off[1]=1 gives bits 31:16; off[0] is ignored.
  - Word: all 32 bits.
  - Byte and half are extended to 32 bits: sign-extended from their MSB unless unsigned, in which case zero-extended.
- Writes to register 0 never assert reg_wrt, but the instruction still retires.
- wb_count increments on every cycle with reg_wrt=1 and wraps modulo 2^CNT_WIDTH.

Test Plan:
- ALU write: reset, accept reg=5, alu=0x1234_5678 -> reg_wrt=1 exactly one cycle later, wrt_reg=5, wrt_dt=0x12345678, wb_count=1.
- Register 0: accept an ALU op to reg 0 -> reg_wrt stays 0, wb_count unchanged; a back-to-back ALU op to reg 3 the next cycle -> reg_wrt=1 with wrt_reg=3.
- Signed byte load: addr low bits=2, size=00, signed; mem_rvalid 3 cycles later with rdata=0x0080_0000 -> wrt_dt=0xFFFF_FF80. in_ready=0 and pend_valid=1/pend_reg correct while waiting.
- Unsigned half load: addr low bits=2, size=01, unsigned; rdata=0xBEEF_1234 -> wrt_dt=0x0000_BEEF.
- Timeout: TIMEOUT=4, load accepted, no mem_rvalid -> err pulses one cycle, no reg_wrt, in_ready=1 again, pend_valid=0. A later mem_rvalid pulse in IDLE is ignored.
- Reset mid-load: rst_n=0 in WAIT_MEM then mem_rvalid -> no write, all outputs 0, state IDLE after reset releases.
